vic_irq_arbiter: RTL and testbench
==================================

Name: vic_irq_arbiter

Overview:
- Vectored IRQ priority arbiter directly downstream of the VIC register/status stage.
- Consumes the masked IRQ status and the 16 vector-control slots, and selects the highest-priority pending vectored source (slot 0 highest).
- Tracks in-service nesting between the VectAddr read (acknowledge) and the VectAddr write (end of interrupt).
- Drives the handler number used to index the vector address registers, plus the nVICIRQ request.

Parameters:
NSLOT, 16, number of vectored slots (index width fixed at 4 bits; NSLOT <= 16)
NSRC, 32, number of interrupt sources (source field width 5 bits)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-low
irq_status  input  NSRC  IRQ status: enabled, not FIQ-selected, raw|soft, synchronous to clk
slot_en  input  NSLOT  VectCntl enable bit per slot
slot_src  input  NSLOT*5  VectCntl source field per slot; slot i at [5i+4:5i]
irq_en  input  1  global IRQ enable (VICIRQEn)
vect_rd  input  1  one-cycle pulse: CPU read of VectAddr, i.e. acknowledge
vect_wr  input  1  one-cycle pulse: CPU write of VectAddr, i.e. end of interrupt (EOI)
handler_num  output  4  registered winning slot index
handler_vect  output  1  1 = handler_num valid vectored slot; 0 = default vector
ack_num  output  5  slot latched at last acknowledge: 0..15 = slot, 16 = default, 31 = none
in_service  output  NSLOT+1  in-service bits; bit NSLOT = default (non-vectored) handler
nirq  output  1  registered active-low IRQ request to core

Behaviour:
- Reset (async, rst=0): handler_num=0, handler_vect=0, ack_num=31, in_service=0, nirq=1.
- Slot request: req[i] = slot_en[i] & irq_status[slot_src[i]].
- Nonvectored pending: nv = |(irq_status & ~covered).
  - covered = OR over enabled slots of (1 << slot_src[i]).
  - A source mapped to several slots is covered; each mapping slot can request.
- Priority ceiling: cur = lowest index set in in_service[NSLOT-1:0].
  - If only the default bit is set, cur = NSLOT.
  - If in_service = 0, cur = NSLOT+1.
- Eligible slot: req[i] & (i < cur). Winner = lowest eligible index.
- Eligible default: nv & (in_service == 0). The default handler never nests and is never preempted by another default.
- Each clk:
  - Winner exists: handler_num <= winner, handler_vect <= 1.
  - No winner: handler_vect <= 0, handler_num holds.
  - nirq <= ~(irq_en & (winner exists | eligible default)).
- Latency: 1 cycle from an irq_status/slot change to handler_num/nirq. Deassertion of a source drops nirq 1 cycle later, even before acknowledge.
- Acknowledge (vect_rd), using the currently registered outputs:
  - handler_vect=1: in_service[handler_num] <= 1, ack_num <= handler_num.
  - Else if nirq=0 (default eligible): in_service[NSLOT] <= 1, ack_num <= 16.
  - Else (spurious read): no in_service change, ack_num <= 16.
- EOI (vect_wr):
  - Clears the lowest-index set bit of in_service (default bit counts as index NSLOT).
  - ack_num <= new lowest set index, or 31 if none remain.
  - EOI with in_service = 0 is ignored.
- Simultaneous vect_rd and vect_wr: EOI is computed on the pre-cycle in_service, then the acknowledge set is applied. If both target the same bit, set wins and ack_num = acknowledged slot.
- Nesting: a higher-priority slot raising during service asserts nirq again. A second acknowledge stacks its bit; its EOI restores the ceiling of the previous level.
- irq_en=0 forces nirq=1 only. Arbitration, in_service and EOI continue.
- Configuration changes (slot_en/slot_src) take effect on the next cycle. in_service is not modified by configuration changes.
- No combinational path from any input to any output.

Test Plan:
- Reset: hold rst=0 with all inputs active -> nirq=1, ack_num=31, in_service=0; release rst -> first response 1 cycle after the next clk edge.
- Priority: slot3 src=7, slot1 src=9, slot_en=0x000A, irq_status bits 7 and 9 set, irq_en=1 -> next cycle handler_num=1, handler_vect=1, nirq=0; pulse vect_rd -> in_service=0x00002, ack_num=1, nirq=1 (slot3 blocked by ceiling).
- Nesting: in_service=0x00008 (slot3 active), raise source of slot0 -> nirq=0, handler_num=0; vect_rd -> in_service=0x00009; vect_wr -> in_service=0x00008, ack_num=3; vect_wr -> in_service=0, ack_num=31.
- Default: irq_status bit 20 set, no slot maps src 20 -> handler_vect=0, nirq=0; vect_rd -> in_service=0x10000, ack_num=16; set irq_status bit 21 (also unmapped) -> nirq stays 1; vect_wr -> in_service=0.
- Simultaneous: in_service=0x00002, slot0 pending, vect_rd and vect_wr in same cycle -> in_service=0x00001, ack_num=0.
- Gating/spurious: irq_en=0 with a request pending -> nirq=1, handler_num still updated; vect_wr with in_service=0 -> no change; vect_rd with nothing pending -> in_service=0, ack_num=16.

Source files
------------

// File: rtl/vic_irq_arbiter_if.sv
// Bus between the VIC register/status stage and the vectored IRQ arbiter.
// The master is the register stage. The slave is the arbiter.
interface vic_irq_arbiter_if #(
  parameter int NSLOT = 16,
  parameter int NSRC  = 32
);
  logic [NSRC-1:0]    irq_status;
  logic [NSLOT-1:0]   slot_en;
  logic [NSLOT*5-1:0] slot_src;
  logic               irq_en;
  logic               vect_rd;
  logic               vect_wr;
  logic [3:0]         handler_num;
  logic               handler_vect;
  logic [4:0]         ack_num;
  logic [NSLOT:0]     in_service;
  logic               nirq;

  modport master (
    output irq_status, slot_en, slot_src, irq_en, vect_rd, vect_wr,
    input  handler_num, handler_vect, ack_num, in_service, nirq
  );

  modport slave (
    input  irq_status, slot_en, slot_src, irq_en, vect_rd, vect_wr,
    output handler_num, handler_vect, ack_num, in_service, nirq
  );
endinterface

// File: rtl/vic_irq_arbiter.sv
// Vectored IRQ priority arbiter with an in-service nesting stack.
// Slot 0 has the highest priority. All outputs are registered.
module vic_irq_arbiter #(
  parameter int NSLOT = 16,
  parameter int NSRC  = 32
) (
  input logic              clk,
  input logic              rst,
  vic_irq_arbiter_if.slave bus
);

  localparam logic [4:0] IDX_DEF  = 5'(NSLOT);
  localparam logic [4:0] IDX_IDLE = 5'(NSLOT + 1);
  localparam logic [4:0] IDX_NONE = 5'd31;

  // Lowest set index of an in-service vector. The default bit is at index NSLOT.
  function automatic logic [4:0] lowest_idx(input logic [NSLOT:0] v);
    logic [4:0] idx;
    idx = IDX_NONE;
    for (int i = NSLOT; i >= 0; i--) begin
      idx = v[i] ? 5'(i) : idx;
    end
    return idx;
  endfunction

  logic [NSLOT-1:0] req_s;
  logic [NSRC-1:0]  covered_s;
  logic             nv_s;
  logic [4:0]       cur_s;
  logic             win_s;
  logic [3:0]       win_idx_s;
  logic             def_elig_s;
  logic [4:0]       src_s;

  logic [3:0]       handler_num_q, handler_num_d;
  logic             handler_vect_q, handler_vect_d;
  logic [4:0]       ack_num_q, ack_num_d;
  logic [NSLOT:0]   in_service_q, in_service_d;
  logic             nirq_q, nirq_d;

  // Slot requests, source coverage, priority ceiling and winner selection.
  always_comb begin
    req_s     = '0;
    covered_s = '0;
    src_s     = 5'd0;
    for (int i = 0; i < NSLOT; i++) begin
      src_s = bus.slot_src[5*i +: 5];
      if (32'(src_s) < NSRC) begin
        req_s[i] = bus.slot_en[i] & bus.irq_status[src_s];
        if (bus.slot_en[i]) begin
          covered_s[src_s] = 1'b1;
        end else begin
          covered_s[src_s] = covered_s[src_s];
        end
      end else begin
        req_s[i] = 1'b0;
      end
    end
    nv_s = |(bus.irq_status & ~covered_s);

    if (in_service_q == '0) begin
      cur_s = IDX_IDLE;
    end else begin
      cur_s = lowest_idx(in_service_q);
    end

    win_s     = 1'b0;
    win_idx_s = 4'd0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (req_s[i] && (5'(i) < cur_s)) begin
        win_s     = 1'b1;
        win_idx_s = 4'(i);
      end else begin
        win_s     = win_s;
      end
    end

    // The default handler never nests, not even under another default.
    def_elig_s = nv_s & (in_service_q == '0);
  end

  // Next-state logic for the registered outputs and the in-service stack.
  always_comb begin
    handler_num_d  = win_s ? win_idx_s : handler_num_q;
    handler_vect_d = win_s;
    nirq_d         = ~(bus.irq_en & (win_s | def_elig_s));
    in_service_d   = in_service_q;
    ack_num_d      = ack_num_q;

    // EOI works on the pre-cycle stack, so a same-cycle acknowledge can re-set the bit.
    if (bus.vect_wr && (in_service_q != '0)) begin
      in_service_d[lowest_idx(in_service_q)] = 1'b0;
      ack_num_d = lowest_idx(in_service_d);
    end else begin
      ack_num_d = ack_num_q;
    end

    if (bus.vect_rd) begin
      if (handler_vect_q) begin
        in_service_d[{1'b0, handler_num_q}] = 1'b1;
        ack_num_d = {1'b0, handler_num_q};
      end else if (!nirq_q) begin
        in_service_d[NSLOT] = 1'b1;
        ack_num_d = IDX_DEF;
      end else begin
        ack_num_d = IDX_DEF;
      end
    end else begin
      in_service_d = in_service_d;
    end
  end

  // Output and in-service registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      handler_num_q  <= 4'd0;
      handler_vect_q <= 1'b0;
      ack_num_q      <= IDX_NONE;
      in_service_q   <= '0;
      nirq_q         <= 1'b1;
    end else begin
      handler_num_q  <= handler_num_d;
      handler_vect_q <= handler_vect_d;
      ack_num_q      <= ack_num_d;
      in_service_q   <= in_service_d;
      nirq_q         <= nirq_d;
    end
  end

  assign bus.handler_num  = handler_num_q;
  assign bus.handler_vect = handler_vect_q;
  assign bus.ack_num      = ack_num_q;
  assign bus.in_service   = in_service_q;
  assign bus.nirq         = nirq_q;

endmodule

// File: tb/tb_vic_irq_arbiter.sv
// Directed bench for vic_irq_arbiter. Expected values are hand-computed.
module tb_vic_irq_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  vic_irq_arbiter_if #(.NSLOT(16), .NSRC(32)) bus ();

  vic_irq_arbiter #(.NSLOT(16), .NSRC(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_src(input int slot, input logic [4:0] src);
    bus.slot_src[5*slot +: 5] = src;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.irq_status = '1;
    bus.slot_en    = '1;
    bus.slot_src   = '0;
    bus.irq_en     = 1'b1;
    bus.vect_rd    = 1'b1;
    bus.vect_wr    = 1'b1;
    tick(3);
    check("rst_nirq",   32'(bus.nirq),         32'd1);
    check("rst_ack",    32'(bus.ack_num),      32'd31);
    check("rst_insvc",  32'(bus.in_service),   32'h0);
    check("rst_hnum",   32'(bus.handler_num),  32'd0);
    check("rst_hvect",  32'(bus.handler_vect), 32'd0);

    // Priority: slot3 -> src7, slot1 -> src9.
    bus.vect_rd = 1'b0;
    bus.vect_wr = 1'b0;
    bus.slot_src = '0;
    set_src(3, 5'd7);
    set_src(1, 5'd9);
    bus.slot_en    = 16'h000A;
    bus.irq_status = 32'h0000_0280;
    rst = 1'b1;
    #1;
    check("rel_nirq_hold", 32'(bus.nirq), 32'd1);
    tick(1);
    check("pri_hnum",  32'(bus.handler_num),  32'd1);
    check("pri_hvect", 32'(bus.handler_vect), 32'd1);
    check("pri_nirq",  32'(bus.nirq),         32'd0);
    bus.vect_rd = 1'b1;
    tick(1);
    bus.vect_rd = 1'b0;
    check("pri_insvc", 32'(bus.in_service), 32'h2);
    check("pri_ack",   32'(bus.ack_num),    32'd1);
    tick(1);
    check("pri_ceiling_nirq", 32'(bus.nirq), 32'd1);
    bus.vect_wr = 1'b1;
    tick(1);
    bus.vect_wr = 1'b0;
    check("pri_eoi_insvc", 32'(bus.in_service), 32'h0);
    check("pri_eoi_ack",   32'(bus.ack_num),    32'd31);

    // Nesting: slot3 in service, slot0 (src0) preempts.
    bus.irq_status = 32'h0000_0080;
    tick(1);
    check("nest_hnum3", 32'(bus.handler_num), 32'd3);
    bus.vect_rd = 1'b1;
    tick(1);
    bus.vect_rd = 1'b0;
    check("nest_insvc8", 32'(bus.in_service), 32'h8);
    bus.slot_en    = 16'h000B;
    bus.irq_status = 32'h0000_0081;
    tick(1);
    check("nest_nirq", 32'(bus.nirq),        32'd0);
    check("nest_hnum0", 32'(bus.handler_num), 32'd0);
    bus.vect_rd = 1'b1;
    tick(1);
    bus.vect_rd = 1'b0;
    bus.irq_status = 32'h0000_0080;
    check("nest_insvc9", 32'(bus.in_service), 32'h9);
    check("nest_ack0",   32'(bus.ack_num),    32'd0);
    bus.vect_wr = 1'b1;
    tick(1);
    check("nest_eoi1_insvc", 32'(bus.in_service), 32'h8);
    check("nest_eoi1_ack",   32'(bus.ack_num),    32'd3);
    tick(1);
    bus.vect_wr = 1'b0;
    bus.irq_status = '0;
    check("nest_eoi2_insvc", 32'(bus.in_service), 32'h0);
    check("nest_eoi2_ack",   32'(bus.ack_num),    32'd31);
    tick(1);

    // Default handler: unmapped source 20, then 21.
    bus.irq_status = 32'h0010_0000;
    tick(1);
    check("def_hvect", 32'(bus.handler_vect), 32'd0);
    check("def_nirq",  32'(bus.nirq),         32'd0);
    bus.vect_rd = 1'b1;
    tick(1);
    bus.vect_rd = 1'b0;
    check("def_insvc", 32'(bus.in_service), 32'h10000);
    check("def_ack",   32'(bus.ack_num),    32'd16);
    bus.irq_status = 32'h0030_0000;
    tick(2);
    check("def_no_nest_nirq", 32'(bus.nirq), 32'd1);
    bus.vect_wr = 1'b1;
    tick(1);
    bus.vect_wr = 1'b0;
    bus.irq_status = '0;
    check("def_eoi_insvc", 32'(bus.in_service), 32'h0);
    tick(1);

    // Simultaneous acknowledge and EOI.
    bus.irq_status = 32'h0000_0200;
    tick(1);
    bus.vect_rd = 1'b1;
    tick(1);
    bus.vect_rd = 1'b0;
    check("sim_insvc2", 32'(bus.in_service), 32'h2);
    bus.irq_status = 32'h0000_0201;
    tick(1);
    check("sim_hnum0", 32'(bus.handler_num), 32'd0);
    bus.vect_rd = 1'b1;
    bus.vect_wr = 1'b1;
    tick(1);
    bus.vect_rd = 1'b0;
    bus.vect_wr = 1'b0;
    bus.irq_status = '0;
    check("sim_insvc", 32'(bus.in_service), 32'h1);
    check("sim_ack",   32'(bus.ack_num),    32'd0);
    bus.vect_wr = 1'b1;
    tick(1);
    bus.vect_wr = 1'b0;
    check("sim_eoi_insvc", 32'(bus.in_service), 32'h0);

    // Deassertion before acknowledge drops the request.
    bus.irq_status = 32'h0000_0080;
    tick(1);
    check("drop_nirq_on", 32'(bus.nirq), 32'd0);
    bus.irq_status = '0;
    tick(1);
    check("drop_nirq_off", 32'(bus.nirq), 32'd1);

    // Gating, EOI when idle, spurious acknowledge.
    bus.irq_en     = 1'b0;
    bus.irq_status = 32'h0000_0080;
    tick(1);
    check("gate_nirq",  32'(bus.nirq),         32'd1);
    check("gate_hnum",  32'(bus.handler_num),  32'd3);
    check("gate_hvect", 32'(bus.handler_vect), 32'd1);
    bus.vect_wr = 1'b1;
    tick(1);
    bus.vect_wr = 1'b0;
    check("idle_eoi_insvc", 32'(bus.in_service), 32'h0);
    check("idle_eoi_ack",   32'(bus.ack_num),    32'd31);
    bus.irq_en     = 1'b1;
    bus.irq_status = '0;
    tick(1);
    bus.vect_rd = 1'b1;
    tick(1);
    bus.vect_rd = 1'b0;
    check("spur_insvc", 32'(bus.in_service), 32'h0);
    check("spur_ack",   32'(bus.ack_num),    32'd16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
